dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Memory-stage data-memory access unit for the 5-stage RV32 pipeline. It takes the load/store request of the instruction in EX/MEM and runs a valid/ready transaction on the data-memory bus. It aligns store data into byte lanes, and extracts and sign- or zero-extends load data into the value captured by the MEM/WB register. While a transaction is outstanding it asserts `busy`, which the hazard unit uses to deassert the pipeline-register enables.

## Interface
- `TIMEOUT_CYCLES`, 256: maximum WAIT cycles without `dmem_ready` before the access is aborted with a timeout fault; ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  instruction in EX/MEM is a load or store.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend load (LBU/LHU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `flush`  in  1  pipeline flush; cancels the current access.
- `busy`  out  1  stall request.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `fault_misaligned`  out  1  qualified by `resp_valid`.
- `fault_timeout`  out  1  qualified by `resp_valid`.
- `dmem_req`  out  1  bus request; held until `dmem_ready`.
- `dmem_we`  out  1  write.
- `dmem_addr`  out  32  `{req_addr[31:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_wstrb`  out  4  byte enables; 0000 for loads.
- `dmem_ready`  in  1  bus completion.
- `dmem_rdata`  in  32  read word, valid with `dmem_ready`.

## Operation
- FSM states:
  - **IDLE**: no access in progress.
  - **WAIT**: bus request outstanding.
  - **DRAIN**: flushed, waiting for the outstanding bus response.
  - **DONE**: one-cycle response.
- Reset: state IDLE, timeout counter 0, every output 0.
- **IDLE** transitions:
  - If `req_valid & !flush`, the request is accepted. Latch `is_store`, `size`, `unsigned`, `addr[1:0]`, bus address, `wdata` and `wstrb`.
  - Misaligned requests go to DONE with `fault_misaligned`, and no bus cycle is issued. Misaligned means half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11.
  - All other accepted requests go to WAIT.
- **WAIT** transitions:
  - `dmem_req=1`, with `dmem_we`/`dmem_addr`/`dmem_wdata`/`dmem_wstrb` held stable from the latched values.
  - Counter increments each cycle.
  - `dmem_ready=1` → DONE; for a load, latch the extracted data.
  - Counter reaches `TIMEOUT_CYCLES` with no ready → drop `dmem_req` and go to DONE with `fault_timeout`.
  - `flush` without ready → DRAIN; `flush` with ready → IDLE, response discarded.
- **DRAIN** transitions:
  - `dmem_req` stays high (the bus cannot abort).
  - `dmem_ready` → IDLE, no response.
  - Timeout also → IDLE, no response.
- **DONE** transitions:
  - `resp_valid = !flush`; the faults and `resp_rdata` are registered.
  - New requests are ignored this cycle, so the completing instruction is not reissued.
  - Always → IDLE.
- Store lane alignment:
  - byte: `wdata={4{d[7:0]}}`, `wstrb=0001<<off`.
  - half: `wdata={2{d[15:0]}}`, `wstrb=0011<<off`.
  - word: `wdata=d`, `wstrb=1111`.
- Load extraction:
  - byte: `rdata[8*off+:8]`.
  - half: `rdata[16*off[1]+:16]`.
  - Bit 7 or 15 is replicated unless `unsigned`.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`; it is cleared on entry to WAIT.

## Timing
- `busy` is combinational:
  - 1 in WAIT and DRAIN.
  - 1 in IDLE when a request is accepted.
  - 0 in DONE.
- Zero-wait-state memory:
  - Cycle 0: accept, `busy=1`.
  - Cycle 1: `dmem_req=1`, `dmem_ready=1`, `busy=1`.
  - Cycle 2: DONE, `resp_valid=1`, `busy=0`; the pipeline advances.
  - Load-to-use latency is 2 cycles plus the memory wait states.
- A back-to-back request is accepted in the cycle after DONE.
- A misaligned access takes 1 stall cycle, then DONE.
- `dmem_ready` is sampled only when `dmem_req=1`; ready while in IDLE or DONE is ignored.
- Asynchronous reset in any state returns immediately to IDLE with `dmem_req=0`.

## Test plan
- LB at 0x1003 with `dmem_rdata=0x80FF_1234`, ready on the first cycle → `resp_valid` in cycle 2, `resp_rdata=0xFFFF_FF80`. LBU at the same address → `0x0000_0080`.
- SH `wdata=0xABCD` at 0x2002 → `dmem_wdata=0xABCD_ABCD`, `wstrb=1100`, `dmem_addr=0x2000`, `we=1`. `dmem_req` held through 3 not-ready cycles; `busy` high for 5 cycles.
- LW at 0x3001 → no `dmem_req`, `resp_valid` plus `fault_misaligned` in cycle 1, `busy` for 1 cycle.
- LW with `TIMEOUT_CYCLES=4`, `dmem_ready` never asserted → `dmem_req` high for 4 cycles, then `resp_valid` plus `fault_timeout`, `resp_rdata=0`.
- Flush in WAIT, ready arriving 2 cycles later → state DRAIN, `dmem_req` held until ready, no `resp_valid`, `busy=1` until IDLE.
- Back-to-back LW/SW with `req_valid` held through DONE → exactly two bus transactions and two `resp_valid` pulses. Asserting reset mid-WAIT clears `dmem_req` asynchronously.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
// Handshake: dmem_req stays high with stable we/addr/wdata/wstrb until the cycle dmem_ready=1.
interface dmem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: store lane alignment, load extraction, bus timeout and flush drain.
// dbg_state encoding: 0 IDLE, 1 WAIT, 2 DRAIN, 3 DONE.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault_misaligned,
  output logic        fault_timeout,
  output logic [1:0]  dbg_state,
  dmem_access_unit_if.master dmem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fmis_q, fmis_d;
  logic        fto_q, fto_d;

  logic          misaligned;
  logic [31:0]   lane_wdata;
  logic [3:0]    lane_wstrb;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;

  always_comb begin
    misaligned = 1'b0;
    lane_wdata = req_wdata;
    lane_wstrb = 4'b1111;
    case (req_size)
      2'b00: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        misaligned = req_addr[0];
        lane_wdata = {2{req_wdata[15:0]}};
        lane_wstrb = 4'b0011 << req_addr[1:0];
      end
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = 8'(dmem.dmem_rdata >> {off_q, 3'b000});
    ld_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    fmis_d     = fmis_q;
    fto_d      = fto_q;
    busy       = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          busy       = 1'b1;
          is_store_d = req_is_store;
          size_d     = req_size;
          uns_d      = req_unsigned;
          off_d      = req_addr[1:0];
          addr_d     = req_addr[31:2];
          wdata_d    = lane_wdata;
          wstrb_d    = req_is_store ? lane_wstrb : 4'b0000;
          cnt_d      = '0;
          rdata_d    = '0;
          fmis_d     = misaligned;
          fto_d      = 1'b0;
          state_d    = misaligned ? DONE : WAIT;
        end
      end
      WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_inc;
        if (dmem.dmem_ready) begin
          state_d = flush ? IDLE : DONE;
          rdata_d = is_store_q ? 32'd0 : ld_ext;
        end else if (flush) begin
          // a flush coinciding with the timeout leaves nothing outstanding to drain
          state_d = timeout_hit ? IDLE : DRAIN;
        end else if (timeout_hit) begin
          state_d = DONE;
          fto_d   = 1'b1;
        end
      end
      DRAIN: begin
        busy  = 1'b1;
        cnt_d = cnt_inc;
        if (dmem.dmem_ready || timeout_hit) state_d = IDLE;
      end
      default: begin
        resp_valid = !flush;
        state_d    = IDLE;
        rdata_d    = '0;
        fmis_d     = 1'b0;
        fto_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      fmis_q     <= 1'b0;
      fto_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      fmis_q     <= fmis_d;
      fto_q      <= fto_d;
    end
  end

  assign dmem.dmem_req   = (state_q == WAIT) || (state_q == DRAIN);
  assign dmem.dmem_we    = dmem.dmem_req & is_store_q;
  assign dmem.dmem_addr  = {addr_q, 2'b00};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = dmem.dmem_req ? wstrb_q : 4'b0000;

  assign resp_rdata       = rdata_q;
  assign fault_misaligned = fmis_q;
  assign fault_timeout    = fto_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed and randomized checks of dmem_access_unit against an arithmetic reference model.
module tb_dmem_access_unit;
  localparam int TO = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_is_store = 1'b0, req_unsigned = 1'b0, flush = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        busy, resp_valid, fault_misaligned, fault_timeout;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .fault_misaligned(fault_misaligned), .fault_timeout(fault_timeout),
    .dbg_state(dbg_state), .dmem(bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  int n_resp = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    if (bus.dmem_req && bus.dmem_ready) n_xfer++;
    if (resp_valid) n_resp++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                         input bit uns, input logic [31:0] a);
    int off = int'(a % 4);
    longint v;
    if (sz == 2'd0) begin
      v = longint'((rd >> (8 * off)) & 32'hFF);
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = longint'((rd >> (16 * (off / 2))) & 32'hFFFF);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  // One access; ready arrives on WAIT cycle 'delay' (delay >= TO means never).
  task automatic do_access(input bit st, input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int delay);
    bit mis = m_mis(sz, addr);
    bit tmo = !mis && (delay >= TO);
    if (!st && !mis && !tmo) exp_q.push_back(m_load(rd, sz, uns, addr));
    else exp_q.push_back(32'd0);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #2;
    chk("accept_busy", busy, 1);
    chk("accept_noreq", bus.dmem_req, 0);
    tick();
    req_valid = 1'b0;
    if (!mis) begin
      for (int w = 0; w < TO; w++) begin
        bus.dmem_ready = (w == delay);
        bus.dmem_rdata = (w == delay) ? rd : $urandom();
        #2;
        chk("wait_req", bus.dmem_req, 1);
        chk("wait_busy", busy, 1);
        chk("wait_addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
        chk("wait_we", bus.dmem_we, st);
        chk("wait_wstrb", bus.dmem_wstrb, st ? m_wstrb(sz, addr) : 4'h0);
        if (st) chk("wait_wdata", bus.dmem_wdata, m_wdata(wd, sz));
        tick();
        if (w == delay) break;
      end
      bus.dmem_ready = 1'b0;
    end
    #2;
    chk("done_valid", resp_valid, 1);
    chk("done_busy", busy, 0);
    chk("done_noreq", bus.dmem_req, 0);
    chk("done_fmis", fault_misaligned, mis);
    chk("done_fto", fault_timeout, tmo);
    chk("done_rdata", resp_rdata, exp_q.pop_front());
    tick();
  endtask

  initial begin
    int x0, r0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_fmis", fault_misaligned, 0);
    chk("rst_fto", fault_timeout, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_wstrb", bus.dmem_wstrb, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    tick();
    tick();
    rst = 1'b0;

    // LB / LBU at 0x1003, zero wait states
    do_access(0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF_1234, 0);
    do_access(0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF_1234, 0);
    // SH at 0x2002, three not-ready cycles
    do_access(1, 2'd1, 0, 32'h2002, 32'h0000_ABCD, 32'h0, 3);
    // LW misaligned
    do_access(0, 2'd2, 0, 32'h3001, 32'h0, 32'h0, 0);
    // LW timeout
    do_access(0, 2'd2, 0, 32'h3004, 32'h0, 32'h0, 99);
    // LH signed / unsigned upper half, illegal size
    do_access(0, 2'd1, 0, 32'h4002, 32'h0, 32'h9ABC_1234, 1);
    do_access(0, 2'd1, 1, 32'h4002, 32'h0, 32'h9ABC_1234, 2);
    do_access(1, 2'd3, 0, 32'h4000, 32'h1, 32'h0, 0);

    // ready while idle is ignored
    bus.dmem_ready = 1'b1;
    #2;
    chk("idle_ready_busy", busy, 0);
    tick();
    bus.dmem_ready = 1'b0;
    #2;
    chk("idle_ready_state", dbg_state, ST_IDLE);
    chk("idle_ready_resp", resp_valid, 0);
    tick();

    // flush in WAIT, ready two cycles later
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_addr = 32'h5000;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2;
    chk("drain_state", dbg_state, ST_DRAIN);
    chk("drain_req", bus.dmem_req, 1);
    chk("drain_busy", busy, 1);
    chk("drain_resp", resp_valid, 0);
    tick();
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    #2;
    chk("drain_req2", bus.dmem_req, 1);
    chk("drain_busy2", busy, 1);
    tick();
    bus.dmem_ready = 1'b0;
    #2;
    chk("drain_exit_state", dbg_state, ST_IDLE);
    chk("drain_exit_req", bus.dmem_req, 0);
    chk("drain_exit_busy", busy, 0);
    chk("drain_exit_resp", resp_valid, 0);
    tick();

    // flush during DONE suppresses the response
    req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h5002;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    #2;
    chk("done_flush_resp", resp_valid, 0);
    tick();
    flush = 1'b0;

    // back-to-back LW then SW with req_valid held through DONE
    x0 = n_xfer; r0 = n_resp;
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    tick();
    bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'h1122_3344;
    tick();
    bus.dmem_ready = 1'b0;
    #2;
    chk("b2b_lw_resp", resp_valid, 1);
    chk("b2b_lw_rdata", resp_rdata, m_load(32'h1122_3344, 2'd2, 0, 32'h100));
    chk("b2b_lw_busy", busy, 0);
    tick();
    req_is_store = 1'b1; req_addr = 32'h104; req_wdata = 32'hCAFE_F00D;
    #2;
    chk("b2b_sw_accept", busy, 1);
    tick();
    bus.dmem_ready = 1'b1;
    #2;
    chk("b2b_sw_wdata", bus.dmem_wdata, 32'hCAFE_F00D);
    chk("b2b_sw_wstrb", bus.dmem_wstrb, 4'hF);
    tick();
    bus.dmem_ready = 1'b0;
    #2;
    chk("b2b_sw_resp", resp_valid, 1);
    chk("b2b_sw_rdata", resp_rdata, 0);
    tick();
    req_valid = 1'b0;
    #2;
    chk("b2b_xfers", n_xfer - x0, 2);
    chk("b2b_resps", n_resp - r0, 2);
    tick();

    // async reset mid-WAIT
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_addr = 32'h200;
    tick();
    req_valid = 1'b0;
    #2;
    chk("rst_mid_req_before", bus.dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", bus.dmem_req, 0);
    chk("rst_mid_state", dbg_state, ST_IDLE);
    chk("rst_mid_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // randomized accesses
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int r, dly;
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      a  = $urandom();
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      dly = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 2);
      do_access(bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), a,
                $urandom(), $urandom(), dly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
